display_scan_controller: RTL and testbench

- Time-multiplexes eight hex digits onto a shared 8-digit seven-segment display. Drives a one-hot digit select and the segment bus.
- Replaces the free-running external 1 kHz clock and the external 3-bit sel source. Scan rate comes from a divider on the system clock.
- Provides per-digit enable and decimal-point masks, anti-ghosting blanking at every digit change, and tear-free frame snapshots.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/hex_to_seg7.sv | 11 +
 rtl/display_scan_controller.sv | 122 ++++++++++++
 tb/tb_display_scan_controller.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: digit count,
// hex-to-segment table and select decoding.
package seg7_pkg;

    localparam int unsigned NDIG  = 8;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned SEG_W = 7;

    // Segment patterns {g,f,e,d,c,b,a}, indexed by nibble value.
    localparam logic [15:0][SEG_W-1:0] HEX7 = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [NDIG-1:0] one_hot8(input logic [SEL_W-1:0] s);
        return NDIG'(1) << s;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to seven-segment decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg_c
);

    assign seg_c = HEX7[nibble];

endmodule

// File: rtl/display_scan_controller.sv
// Scans eight hex digits onto a multiplexed seven-segment display with
// per-digit masks, select blanking at digit changes and per-frame snapshots.
module display_scan_controller
    import seg7_pkg::*;
#(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned BLANK = 4,
    parameter int unsigned CW    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [4*NDIG-1:0]         data,
    input  logic [NDIG-1:0]           dp_mask,
    input  logic [NDIG-1:0]           dig_mask,
    output logic [NDIG-1:0]           select,
    output logic [SEG_W:0]            seg,
    output logic [SEL_W-1:0]          sel,
    output logic                      frame_done
);

    localparam logic [CW-1:0]    CNT_MAX  = CW'(DIV - 1);
    localparam logic [CW-1:0]    BLANK_C  = CW'(BLANK);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NDIG - 1);

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                en_q, en_d;
    logic [4*NDIG-1:0]   data_s_q, data_s_d;
    logic [NDIG-1:0]     dp_s_q, dp_s_d;
    logic [NDIG-1:0]     dig_s_q, dig_s_d;
    logic [NDIG-1:0]     select_q, select_d;
    logic [SEG_W:0]      seg_q, seg_d;
    logic                frame_done_q, frame_done_d;

    logic                first_c;
    logic                tick_c;
    logic                wrap_c;
    logic [4*NDIG-1:0]   src_data_c;
    logic [NDIG-1:0]     src_dp_c;
    logic [NDIG-1:0]     src_dig_c;
    logic [3:0]          nibble_c;
    logic [SEG_W-1:0]    seg7_c;

    // On the first enabled cycle the snapshot is still stale, so the
    // output path reads the live inputs it is about to capture.
    always_comb begin
        first_c    = en && !en_q;
        tick_c     = (cnt_q == CNT_MAX);
        wrap_c     = tick_c && (sel_q == LAST_SEL);
        src_data_c = first_c ? data     : data_s_q;
        src_dp_c   = first_c ? dp_mask  : dp_s_q;
        src_dig_c  = first_c ? dig_mask : dig_s_q;
        nibble_c   = 4'(src_data_c >> {sel_q, 2'b00});
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble_c),
        .seg_c  (seg7_c)
    );

    // Divider, slot counter, snapshot and registered display outputs.
    always_comb begin
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        en_d         = en;
        data_s_d     = data_s_q;
        dp_s_d       = dp_s_q;
        dig_s_d      = dig_s_q;
        select_d     = select_q;
        seg_d        = seg_q;
        frame_done_d = 1'b0;

        if (!en) begin
            cnt_d    = '0;
            sel_d    = '0;
            select_d = '0;
            seg_d    = '0;
        end else begin
            cnt_d        = tick_c ? '0 : cnt_q + CW'(1);
            sel_d        = tick_c ? sel_q + SEL_W'(1) : sel_q;
            frame_done_d = wrap_c;
            select_d     = (cnt_q >= BLANK_C && src_dig_c[sel_q]) ? one_hot8(sel_q) : '0;
            seg_d        = src_dig_c[sel_q] ? {src_dp_c[sel_q], seg7_c} : '0;
            if (first_c || wrap_c) begin
                data_s_d = data;
                dp_s_d   = dp_mask;
                dig_s_d  = dig_mask;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            sel_q        <= '0;
            en_q         <= 1'b0;
            data_s_q     <= '0;
            dp_s_q       <= '0;
            dig_s_q      <= '0;
            select_q     <= '0;
            seg_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            en_q         <= en_d;
            data_s_q     <= data_s_d;
            dp_s_q       <= dp_s_d;
            dig_s_q      <= dig_s_d;
            select_q     <= select_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign select     = select_q;
    assign seg        = seg_q;
    assign sel        = sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed self-checking bench for display_scan_controller with DIV=10, BLANK=2.
module tb_display_scan_controller;

    localparam int unsigned DIV   = 10;
    localparam int unsigned BLANK = 2;
    localparam int unsigned NONE  = 99;

    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] data;
    logic [7:0]  dp_mask;
    logic [7:0]  dig_mask;
    logic [7:0]  select;
    logic [7:0]  seg;
    logic [2:0]  sel;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    display_scan_controller #(.DIV(DIV), .BLANK(BLANK), .CW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .data       (data),
        .dp_mask    (dp_mask),
        .dig_mask   (dig_mask),
        .select     (select),
        .seg        (seg),
        .sel        (sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " select"}, 32'(select), 32'h0);
        check({tag, " seg"}, 32'(seg), 32'h0);
        check({tag, " sel"}, 32'(sel), 32'h0);
        check({tag, " frame_done"}, 32'(frame_done), 32'h0);
    endtask

    // Walks nsamp cycles of a frame whose snapshot is (d, dig, dp). Sample k
    // follows the edge at which the controller sat in slot k/10, count k%10.
    // At slot chg_slot, count 5 the inputs switch to (nd, ndig, ndp).
    task automatic run_frame(input logic [31:0] d, input logic [7:0] dig, input logic [7:0] dp,
                             input int unsigned chg_slot, input logic [31:0] nd,
                             input logic [7:0] ndig, input logic [7:0] ndp,
                             input int unsigned nsamp);
        logic [7:0] prev_select;
        logic [7:0] prev_seg;
        logic [7:0] es;
        logic [7:0] eg;
        logic [3:0] nib;
        int unsigned hi;
        int unsigned s;
        int unsigned j;
        prev_select = select;
        prev_seg    = seg;
        hi          = 0;
        for (int unsigned k = 0; k < nsamp; k++) begin
            s = k / DIV;
            j = k % DIV;
            @(posedge clk);
            @(negedge clk);
            if (j == 0) hi = 0;
            nib = 4'(d >> (4 * s));
            es  = (j >= BLANK && dig[s]) ? (8'h01 << s) : 8'h00;
            eg  = dig[s] ? {dp[s], HEX[nib]} : 8'h00;
            check($sformatf("select s%0d c%0d", s, j), 32'(select), 32'(es));
            check($sformatf("seg s%0d c%0d", s, j), 32'(seg), 32'(eg));
            check($sformatf("sel s%0d c%0d", s, j), 32'(sel), 32'((j == DIV - 1) ? (s + 1) % 8 : s));
            check($sformatf("frame_done s%0d c%0d", s, j), 32'(frame_done),
                  32'((s == 7 && j == DIV - 1) ? 1 : 0));
            check($sformatf("onehot s%0d c%0d", s, j), 32'($countones(select) <= 1), 32'h1);
            if (prev_select == 8'h00 && select != 8'h00)
                check($sformatf("seg_at_rise s%0d c%0d", s, j), 32'(seg), 32'(prev_seg));
            if (select != 8'h00) hi++;
            if (j == DIV - 1)
                check($sformatf("high_count s%0d", s), 32'(hi), dig[s] ? 32'd8 : 32'd0);
            prev_select = select;
            prev_seg    = seg;
            if (s == chg_slot && j == 5) begin
                data     = nd;
                dig_mask = ndig;
                dp_mask  = ndp;
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        data     = 32'h76543210;
        dp_mask  = 8'h00;
        dig_mask = 8'hFF;
        #12;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_idle("disabled");

        en = 1'b1;
        run_frame(32'h76543210, 8'hFF, 8'h00, NONE, 32'h0, 8'h0, 8'h0, 80);
        run_frame(32'h76543210, 8'hFF, 8'h00, 3, 32'h76543210, 8'hF5, 8'h01, 80);
        run_frame(32'h76543210, 8'hF5, 8'h01, 3, 32'hFFFFFFFF, 8'hF5, 8'h01, 80);
        run_frame(32'hFFFFFFFF, 8'hF5, 8'h01, 2, 32'hFFFFFFFF, 8'hFF, 8'h00, 80);
        run_frame(32'hFFFFFFFF, 8'hFF, 8'h00, 1, 32'h89ABCDEF, 8'hFF, 8'h80, 80);
        run_frame(32'h89ABCDEF, 8'hFF, 8'h80, 4, 32'h76543210, 8'hFF, 8'h00, 80);

        // Drop en while sitting in slot 5 at count 6.
        run_frame(32'h76543210, 8'hFF, 8'h00, NONE, 32'h0, 8'h0, 8'h0, 56);
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle("en_drop");
        en = 1'b1;
        run_frame(32'h76543210, 8'hFF, 8'h00, NONE, 32'h0, 8'h0, 8'h0, 80);

        // Asynchronous reset between clock edges, mid-slot.
        run_frame(32'h76543210, 8'hFF, 8'h00, NONE, 32'h0, 8'h0, 8'h0, 33);
        data = 32'h0FEDCBA9;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        @(negedge clk);
        check_idle("reset_held");
        rst_n = 1'b1;
        run_frame(32'h0FEDCBA9, 8'hFF, 8'h00, NONE, 32'h0, 8'h0, 8'h0, 80);
        run_frame(32'h0FEDCBA9, 8'hFF, 8'h00, NONE, 32'h0, 8'h0, 8'h0, 80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
